// File: rtl/razor_pkg.sv
// Shared regfile-writeback types and constants for the writeback port arbiter.
package razor_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // x0 is hardwired zero: nothing ever lands there or waits on it
   function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
      return rd != '0;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts at ptr and wraps, ptr moves past each winner.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx
);
   localparam int PW = $clog2(N);
   // one spare bit so ptr+k never overflows before the wrap compare
   typedef logic [PW:0] idx_t;

   logic [PW-1:0] ptr;
   idx_t          cand;
   idx_t          nxt;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = idx_t'(ptr) + idx_t'(k);
         if (cand >= idx_t'(N)) cand = cand - idx_t'(N);
         if (!found && req[cand[PW-1:0]]) begin
            found               = 1'b1;
            gnt[cand[PW-1:0]]   = 1'b1;
            gnt_idx             = cand[PW-1:0];
         end
      end
   end

   always_comb begin
      nxt = idx_t'(gnt_idx) + idx_t'(1);
      if (nxt == idx_t'(N)) nxt = '0;
   end

   always_ff @(posedge clk) begin
      if (rst)       ptr <= '0;
      else if (found) ptr <= nxt[PW-1:0];
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port among NUM_REQ writeback sources and tracks
// outstanding destination registers for decode hazard stalls.
module wb_port_arbiter
   import razor_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = razor_pkg::XLEN
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]  req_rd,
   input  logic [NUM_REQ-1:0][XLEN-1:0]        req_data,
   input  logic                                rsv_valid,
   input  logic [REG_ADDR_W-1:0]               rsv_rd,
   output logic                                wbe_CONTROL,
   output logic [REG_ADDR_W-1:0]               rd_sel,
   output logic [XLEN-1:0]                     rd_in,
   output logic [NUM_REGS-1:0]                 busy_mask
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req_live;
   logic [NUM_REQ-1:0]    gnt;
   logic [IW-1:0]         gnt_idx;
   logic                  any_gnt;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic [NUM_REGS-1:0]   busy_q;
   logic [NUM_REGS-1:0]   busy_d;

   // no grants while reset is asserted, so no handshake can complete
   assign req_live = rst ? '0 : req_valid;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_live),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign any_gnt   = |gnt;
   assign sel_rd    = req_rd[gnt_idx];
   assign sel_data  = req_data[gnt_idx];

   // output stage reloads every cycle, so it never back-pressures the arbiter
   always_ff @(posedge clk) begin
      if (rst) begin
         wbe_CONTROL <= 1'b0;
         rd_sel      <= '0;
         rd_in       <= '0;
      end else begin
         wbe_CONTROL <= any_gnt && writes_reg(sel_rd);
         if (any_gnt) begin
            rd_sel <= sel_rd;
            rd_in  <= sel_data;
         end
      end
   end

   // release on commit first, then reserve, so a same-cycle reserve wins
   always_comb begin
      busy_d = busy_q;
      if (wbe_CONTROL) busy_d[rd_sel] = 1'b0;
      if (rsv_valid && writes_reg(rsv_rd)) busy_d[rsv_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy_mask = busy_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs into a queue, popped and compared one cycle later.
module tb_wb_port_arbiter;
   import razor_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [2:0]            req_valid;
   logic [2:0]            req_ready;
   logic [2:0][4:0]       req_rd;
   logic [2:0][31:0]      req_data;
   logic                  rsv_valid;
   logic [4:0]            rsv_rd;
   logic                  wbe_CONTROL;
   logic [4:0]            rd_sel;
   logic [31:0]           rd_in;
   logic [31:0]           busy_mask;

   wb_port_arbiter #(.NUM_REQ(3), .XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rd      (req_rd),
      .req_data    (req_data),
      .rsv_valid   (rsv_valid),
      .rsv_rd      (rsv_rd),
      .wbe_CONTROL (wbe_CONTROL),
      .rd_sel      (rd_sel),
      .rd_in       (rd_in),
      .busy_mask   (busy_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wbe;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] busy;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   m_ptr    = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
      req_rd[i]   = rd;
      req_data[i] = data;
   endtask

   task automatic step(input logic r, input logic [2:0] v, input logic rv, input logic [4:0] rr);
      exp_t        cur;
      exp_t        nx;
      int          gi;
      logic [2:0]  exp_rdy;
      rst = r; req_valid = v; rsv_valid = rv; rsv_rd = rr;
      @(negedge clk);
      cur = '{wbe: 1'b0, rd: 5'd0, data: 32'd0, busy: 32'd0};
      if (q.size() > 0) begin
         cur = q.pop_front();
         chk("wbe_CONTROL", 64'(wbe_CONTROL), 64'(cur.wbe));
         chk("rd_sel",      64'(rd_sel),      64'(cur.rd));
         chk("rd_in",       64'(rd_in),       64'(cur.data));
         chk("busy_mask",   64'(busy_mask),   64'(cur.busy));
      end
      gi = -1;
      if (!r)
         for (int k = 0; k < 3; k++)
            if (gi < 0 && v[(m_ptr + k) % 3]) gi = (m_ptr + k) % 3;
      exp_rdy = (gi >= 0) ? 3'(1 << gi) : 3'b000;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (r) begin
         nx = '{wbe: 1'b0, rd: 5'd0, data: 32'd0, busy: 32'd0};
         m_ptr = 0;
      end else begin
         nx.busy = cur.busy;
         if (cur.wbe) nx.busy[cur.rd] = 1'b0;
         if (rv && rr != 5'd0) nx.busy[rr] = 1'b1;
         if (gi >= 0) begin
            nx.wbe  = (req_rd[gi] != 5'd0);
            nx.rd   = req_rd[gi];
            nx.data = req_data[gi];
            m_ptr   = (gi + 1) % 3;
         end else begin
            nx.wbe  = 1'b0;
            nx.rd   = cur.rd;
            nx.data = cur.data;
         end
      end
      q.push_back(nx);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; rsv_valid = 1'b0; rsv_rd = '0;
      set_req(0, 5'd1, 32'h1111_0000);
      set_req(1, 5'd2, 32'h2222_0000);
      set_req(2, 5'd3, 32'h3333_0000);
      @(posedge clk);
      #1;

      // reset with every requester valid
      step(1'b1, 3'b111, 1'b0, 5'd0);
      step(1'b1, 3'b111, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      // single request from source 1
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      step(1'b0, 3'b010, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      // fairness from a freshly reset pointer
      step(1'b1, 3'b000, 1'b0, 5'd0);
      set_req(0, 5'd10, 32'hA0A0_0001);
      set_req(1, 5'd11, 32'hB1B1_0002);
      set_req(2, 5'd12, 32'hC2C2_0003);
      for (int c = 0; c < 6; c++) step(1'b0, 3'b111, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      // x0 write: handshake completes, no regfile write
      set_req(0, 5'd0, 32'h0000_1234);
      step(1'b0, 3'b001, 1'b0, 5'd0);
      step(1'b0, 3'b011, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      // scoreboard: reserve, commit, same-cycle reserve+release
      set_req(2, 5'd7, 32'h7777_7777);
      step(1'b0, 3'b000, 1'b1, 5'd7);
      step(1'b0, 3'b000, 1'b1, 5'd0);
      step(1'b0, 3'b100, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b1, 5'd7);
      step(1'b0, 3'b100, 1'b1, 5'd7);
      step(1'b0, 3'b000, 1'b1, 5'd7);
      step(1'b0, 3'b000, 1'b0, 5'd0);
      set_req(0, 5'd3, 32'h3030_3030);
      step(1'b0, 3'b001, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      // reset mid-operation
      set_req(1, 5'd9, 32'h9999_0009);
      step(1'b0, 3'b000, 1'b1, 5'd9);
      step(1'b1, 3'b010, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b1, 5'd9);
      step(1'b0, 3'b010, 1'b0, 5'd0);
      step(1'b1, 3'b000, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      // random traffic
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < 3; i++) set_req(i, 5'($urandom_range(0, 12)), $urandom);
         step(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)));
      end
      step(1'b0, 3'b000, 1'b0, 5'd0);
      step(1'b0, 3'b000, 1'b0, 5'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
